mem_bridge: RTL and testbench

- Sits directly downstream of the processor memory controller and sits between its single 32-bit memory port and the on-chip synchronous program/data SRAM.
- Turns the controller's readstart pulse and level wRAM request into timed SRAM cycles, and returns a readrdy pulse with held read data plus a saverdy acceptance signal.
- Provides a second, write-only loader port (program/boot loader) that shares the SRAM under fixed-priority arbitration.

---
 rtl/mem_bridge.sv | 132 +++++++++++++
 tb/tb_mem_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// Bridge between the CPU memory controller port, a write-only loader port and a
// single-port synchronous SRAM. Reads take priority over controller writes, which beat the loader.
module mem_bridge #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // controller port
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] fromCPU,
  input  logic              wRAM,
  input  logic              readstart,
  output logic [DATA_W-1:0] toCPU,
  output logic              readrdy,
  output logic              saverdy,
  // loader port
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  // SRAM port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE,
    WR,
    LD_WR,
    LD_ACK
  } state_t;

  // Counter only needs to reach RD_LAT-1, and RD_LAT never exceeds 4.
  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t     state;
  logic [1:0] lat_cnt;

  // Combinational so the controller can leave its save state in the capture cycle.
  assign saverdy = (state == IDLE) && !readstart;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values; the async reset also drops the SRAM
  // strobes immediately, mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      toCPU     <= '0;
      readrdy   <= 1'b0;
      ld_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (readstart) begin
            mem_addr <= addr;
            mem_re   <= 1'b1;
            state    <= RD_ISSUE;
          end else if (wRAM) begin
            mem_addr  <= addr;
            mem_wdata <= fromCPU;
            mem_we    <= 1'b1;
            state     <= WR;
          end else if (ld_valid) begin
            mem_addr  <= ld_addr;
            mem_wdata <= ld_data;
            mem_we    <= 1'b1;
            state     <= LD_WR;
          end
        end

        // The read strobe was raised on entry; this is its single active cycle.
        RD_ISSUE: begin
          mem_re  <= 1'b0;
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end

        RD_WAIT: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_cnt == LAST_CNT) begin
            toCPU   <= mem_rdata;
            readrdy <= 1'b1;
            state   <= RD_DONE;
          end
        end

        RD_DONE: begin
          readrdy <= 1'b0;
          state   <= IDLE;
        end

        WR: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end

        LD_WR: begin
          mem_we   <= 1'b0;
          ld_ready <= 1'b1;
          state    <= LD_ACK;
        end

        LD_ACK: begin
          ld_ready <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          mem_we   <= 1'b0;
          mem_re   <= 1'b0;
          readrdy  <= 1'b0;
          ld_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: instance A uses RD_LAT=1, instance B uses RD_LAT=4
// for the reset-abort scenario. Each instance has its own SRAM model.
module tb_mem_bridge;
  localparam int AW = 15;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A (RD_LAT=1) ----------------
  logic          rst_a;
  logic [AW-1:0] addr_a, lda_a, maddr_a;
  logic [DW-1:0] from_a, to_a, ldd_a, mwd_a, mrd_a;
  logic          wram_a, rs_a, rdy_a, save_a, ldv_a, ldr_a, mwe_a, mre_a;

  mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .addr(addr_a), .fromCPU(from_a), .wRAM(wram_a), .readstart(rs_a),
    .toCPU(to_a), .readrdy(rdy_a), .saverdy(save_a),
    .ld_valid(ldv_a), .ld_addr(lda_a), .ld_data(ldd_a), .ld_ready(ldr_a),
    .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_we(mwe_a), .mem_re(mre_a),
    .mem_rdata(mrd_a)
  );

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic          pre_we_a;
  logic [AW-1:0] pre_addr_a;
  logic [DW-1:0] pre_data_a;

  always @(posedge clk) begin
    if (pre_we_a) mem_a[pre_addr_a] <= pre_data_a;
    else if (mwe_a) mem_a[maddr_a] <= mwd_a;
    mrd_a <= mre_a ? mem_a[maddr_a] : '0;
  end

  // ---------------- instance B (RD_LAT=4) ----------------
  logic          rst_b;
  logic [AW-1:0] addr_b, lda_b, maddr_b;
  logic [DW-1:0] from_b, to_b, ldd_b, mwd_b, mrd_b;
  logic          wram_b, rs_b, rdy_b, save_b, ldv_b, ldr_b, mwe_b, mre_b;

  mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .addr(addr_b), .fromCPU(from_b), .wRAM(wram_b), .readstart(rs_b),
    .toCPU(to_b), .readrdy(rdy_b), .saverdy(save_b),
    .ld_valid(ldv_b), .ld_addr(lda_b), .ld_data(ldd_b), .ld_ready(ldr_b),
    .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_we(mwe_b), .mem_re(mre_b),
    .mem_rdata(mrd_b)
  );

  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] pipe_b [4];
  logic          pre_we_b;
  logic [AW-1:0] pre_addr_b;
  logic [DW-1:0] pre_data_b;

  always @(posedge clk) begin
    if (pre_we_b) mem_b[pre_addr_b] <= pre_data_b;
    else if (mwe_b) mem_b[maddr_b] <= mwd_b;
    pipe_b[0] <= mre_b ? mem_b[maddr_b] : '0;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign mrd_b = pipe_b[3];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_rd_a[$];
  logic [DW-1:0] exp_rd_b[$];
  wr_t           exp_wr_a[$];
  int            exp_ld_a[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr_a.push_back(w);
  endtask

  // Monitor: pops an expectation whenever a DUT presents a response.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    wr_t           w;
    int            dummy;
    if (rdy_a) begin
      if (exp_rd_a.size() == 0) check("a_unexpected_readrdy", 1, 0);
      else begin
        e = exp_rd_a.pop_front();
        check("a_read_data", to_a, e);
      end
    end
    if (mwe_a) begin
      if (exp_wr_a.size() == 0) check("a_unexpected_write", 1, 0);
      else begin
        w = exp_wr_a.pop_front();
        check("a_write_addr", maddr_a, w.a);
        check("a_write_data", mwd_a, w.d);
      end
    end
    if (ldr_a) begin
      if (exp_ld_a.size() == 0) check("a_unexpected_ld_ready", 1, 0);
      else dummy = exp_ld_a.pop_front();
    end
    if (mwe_a && mre_a) check("a_we_re_exclusive", 1, 0);
    if (rdy_b) begin
      if (exp_rd_b.size() == 0) check("b_unexpected_readrdy", 1, 0);
      else begin
        e = exp_rd_b.pop_front();
        check("b_read_data", to_b, e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_read(input logic [AW-1:0] ad, input logic [DW-1:0] exp);
    bit seen = 0;
    exp_rd_a.push_back(exp);
    addr_a = ad;
    rs_a   = 1'b1;
    tick();
    rs_a = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rdy_a) seen = 1;
    end
    if (!seen) check("a_read_timeout", 0, 1);
    tick();
  endtask

  task automatic b_read(input logic [AW-1:0] ad, input logic [DW-1:0] exp);
    bit seen = 0;
    exp_rd_b.push_back(exp);
    addr_b = ad;
    rs_b   = 1'b1;
    tick();
    rs_b = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rdy_b) seen = 1;
    end
    if (!seen) check("b_read_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    rst_a = 1'b1; rst_b = 1'b1;
    addr_a = '0; from_a = '0; wram_a = 1'b0; rs_a = 1'b0;
    ldv_a = 1'b0; lda_a = '0; ldd_a = '0;
    addr_b = '0; from_b = '0; wram_b = 1'b0; rs_b = 1'b0;
    ldv_b = 1'b0; lda_b = '0; ldd_b = '0;
    pre_we_a = 1'b0; pre_addr_a = '0; pre_data_a = '0;
    pre_we_b = 1'b0; pre_addr_b = '0; pre_data_b = '0;

    repeat (2) tick();
    @(negedge clk);
    check("rst_toCPU", to_a, 0);
    check("rst_readrdy", rdy_a, 0);
    check("rst_ld_ready", ldr_a, 0);
    check("rst_mem_addr", maddr_a, 0);
    check("rst_mem_wdata", mwd_a, 0);
    check("rst_mem_we", mwe_a, 0);
    check("rst_mem_re", mre_a, 0);
    check("rst_b_toCPU", to_b, 0);
    tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // Preload SRAM words.
    pre_we_a = 1'b1; pre_addr_a = 15'h0005; pre_data_a = 32'hA5A5_1234;
    pre_we_b = 1'b1; pre_addr_b = 15'h0009; pre_data_b = 32'h9999_AAAA;
    tick();
    pre_addr_a = 15'h0020; pre_data_a = 32'h1111_2222;
    pre_addr_b = 15'h000C; pre_data_b = 32'h0C0C_0C0C;
    tick();
    pre_we_a = 1'b0; pre_we_b = 1'b0;
    tick();

    // Read latency, RD_LAT=1.
    exp_rd_a.push_back(32'hA5A5_1234);
    addr_a = 15'h0005; rs_a = 1'b1;
    @(negedge clk); check("rd_saverdy_c0", save_a, 0);
    tick(); rs_a = 1'b0;
    @(negedge clk); check("rd_mem_re_c1", mre_a, 1); check("rd_mem_addr_c1", maddr_a, 15'h0005);
    check("rd_readrdy_c1", rdy_a, 0);
    tick();
    @(negedge clk); check("rd_mem_re_c2", mre_a, 0); check("rd_readrdy_c2", rdy_a, 0);
    tick();
    @(negedge clk); check("rd_readrdy_c3", rdy_a, 1); check("rd_toCPU_c3", to_a, 32'hA5A5_1234);
    tick();
    @(negedge clk); check("rd_readrdy_c4", rdy_a, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk); check("rd_toCPU_hold", to_a, 32'hA5A5_1234);
    end
    tick();

    // Level write.
    push_wr(15'h0011, 32'hDEAD_BEEF);
    wram_a = 1'b1; addr_a = 15'h0011; from_a = 32'hDEAD_BEEF;
    @(negedge clk); check("wr_saverdy_c0", save_a, 1);
    tick(); wram_a = 1'b0;
    @(negedge clk); check("wr_mem_we_c1", mwe_a, 1);
    tick();
    @(negedge clk); check("wr_mem_we_c2", mwe_a, 0); check("wr_toCPU_unchanged", to_a, 32'hA5A5_1234);
    check("wr_idle_saverdy_no_req", save_a, 1);
    tick();
    @(negedge clk); check("wr_no_spurious_we", mwe_a, 0);
    tick();
    a_read(15'h0011, 32'hDEAD_BEEF);

    // Collision: read, then controller write, then loader.
    exp_rd_a.push_back(32'h1111_2222);
    push_wr(15'h0020, 32'hCAFE_F00D);
    push_wr(15'h0030, 32'h3333_4444);
    exp_ld_a.push_back(1);
    addr_a = 15'h0020; rs_a = 1'b1; wram_a = 1'b1; from_a = 32'hCAFE_F00D;
    ldv_a = 1'b1; lda_a = 15'h0030; ldd_a = 32'h3333_4444;
    @(negedge clk); check("col_saverdy_c0", save_a, 0);
    tick(); rs_a = 1'b0;
    @(negedge clk); check("col_mem_re_c1", mre_a, 1); check("col_mem_we_c1", mwe_a, 0);
    tick(); tick();
    @(negedge clk); check("col_readrdy_c3", rdy_a, 1);
    tick();
    @(negedge clk); check("col_saverdy_c4", save_a, 1); check("col_mem_we_c4", mwe_a, 0);
    tick(); wram_a = 1'b0;
    @(negedge clk); check("col_mem_we_c5", mwe_a, 1); check("col_addr_c5", maddr_a, 15'h0020);
    tick();
    @(negedge clk); check("col_mem_we_c6", mwe_a, 0); check("col_ld_ready_c6", ldr_a, 0);
    tick();
    @(negedge clk); check("col_mem_we_c7", mwe_a, 1); check("col_addr_c7", maddr_a, 15'h0030);
    tick();
    @(negedge clk); check("col_ld_ready_c8", ldr_a, 1);
    tick(); ldv_a = 1'b0;
    @(negedge clk); check("col_ld_ready_c9", ldr_a, 0); check("col_mem_we_c9", mwe_a, 0);
    tick();
    a_read(15'h0020, 32'hCAFE_F00D);
    a_read(15'h0030, 32'h3333_4444);

    // Loader at the top address.
    push_wr(15'h7FFF, 32'h0123_4567);
    exp_ld_a.push_back(1);
    ldv_a = 1'b1; lda_a = 15'h7FFF; ldd_a = 32'h0123_4567;
    @(negedge clk); check("ld_mem_we_c0", mwe_a, 0);
    tick();
    @(negedge clk); check("ld_mem_we_c1", mwe_a, 1); check("ld_addr_c1", maddr_a, 15'h7FFF);
    tick();
    @(negedge clk); check("ld_ready_c2", ldr_a, 1);
    tick(); ldv_a = 1'b0;
    @(negedge clk); check("ld_ready_c3", ldr_a, 0);
    tick();
    a_read(15'h7FFF, 32'h0123_4567);

    // Second readstart during RD_WAIT is dropped.
    exp_rd_a.push_back(32'hA5A5_1234);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      rs_a   = (c == 0 || c == 2);
      addr_a = (c >= 2) ? 15'h0011 : 15'h0005;
      @(negedge clk);
      if (rdy_a) cnt++;
      tick();
    end
    rs_a = 1'b0;
    check("ign_readrdy_count", cnt, 1);
    @(negedge clk); check("ign_back_idle", save_a, 1);
    tick();

    // RD_LAT=4 latency: readrdy exactly in cycle 6.
    exp_rd_b.push_back(32'h9999_AAAA);
    addr_b = 15'h0009; rs_b = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); check("b_readrdy_timing", rdy_b, (c == 6) ? 1 : 0);
      tick();
      rs_b = 1'b0;
    end
    @(negedge clk); check("b_toCPU_after_read", to_b, 32'h9999_AAAA);
    tick();

    // Reset in cycle 2 after readstart aborts the read.
    addr_b = 15'h000C; rs_b = 1'b1;
    tick(); rs_b = 1'b0;
    tick(); rst_b = 1'b1;
    #1;
    check("b_abort_mem_re", mre_b, 0);
    check("b_abort_readrdy", rdy_b, 0);
    check("b_abort_toCPU", to_b, 0);
    tick(); tick(); rst_b = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rdy_b) cnt++;
      tick();
    end
    check("b_abort_no_readrdy", cnt, 0);

    // Reset while mem_re is high drops it without waiting for a clock.
    addr_b = 15'h000C; rs_b = 1'b1;
    tick(); rs_b = 1'b0;
    @(negedge clk); check("b_async_re_pre", mre_b, 1);
    #1 rst_b = 1'b1;
    #1 check("b_async_re_drop", mre_b, 0);
    tick(); rst_b = 1'b0;
    tick();
    b_read(15'h000C, 32'h0C0C_0C0C);
    @(negedge clk); check("b_final_toCPU", to_b, 32'h0C0C_0C0C);
    tick();

    check("a_rd_queue_empty", exp_rd_a.size(), 0);
    check("a_wr_queue_empty", exp_wr_a.size(), 0);
    check("a_ld_queue_empty", exp_ld_a.size(), 0);
    check("b_rd_queue_empty", exp_rd_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
